midi_msg_parser: RTL and testbench
==================================

# midi_msg_parser

Downstream of the single-byte MIDI receiver (`single_midi_in`). It consumes that block's byte stream (`data_rx`, `is_command`, `new_byte_strobe`) and assembles complete MIDI channel-voice messages, handling running status, interleaved real-time bytes and SysEx skipping. Each complete message is presented as one registered, single-cycle strobe with decoded fields for the synth/voice logic that follows.

## Interface

Parameters:
- `OMNI`, 1: 1 = accept all channels; 0 = accept only `LISTEN_CH`.
- `LISTEN_CH`, 4'd0: channel (0-15) accepted when `OMNI`=0.

Ports:
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `data_rx` in 8: received byte; valid while `new_byte_strobe` is high.
- `is_command` in 1: byte is a status byte (bit 7 set).
- `new_byte_strobe` in 1: one-cycle pulse per received byte.
- `msg_valid` out 1: one-cycle pulse when a complete channel message is accepted.
- `msg_type` out 4: status high nibble (0x8-0xE).
- `msg_channel` out 4: status low nibble.
- `msg_data1` out 7: first data byte (note, controller, program, etc.).
- `msg_data2` out 7: second data byte; 0 for one-data-byte messages.
- `rt_valid` out 1: one-cycle pulse for a real-time byte (0xF8-0xFF).
- `rt_byte` out 8: last real-time byte.

## Operation

- Inputs are sampled only on cycles where `new_byte_strobe`=1; other cycles are ignored.
- Registers: `run_status[7:0]`, which is 0 when no running status is held; `d1_hold[6:0]`; and `state`.
- States:
  - `IDLE`: no usable running status.
  - `WAIT_D1`: status known, expecting the first data byte.
  - `WAIT_D2`: expecting the second data byte.
  - `SYSEX`: discarding bytes until EOX.
- Data-byte count by type: 0x8, 0x9, 0xA, 0xB, 0xE take 2; 0xC, 0xD take 1.
- Real-time bytes (0xF8-0xFF), in any state:
  - Pulse `rt_valid` and load `rt_byte`.
  - `state`, `run_status` and `d1_hold` are unchanged, so real-time bytes may interleave mid-message.
- Status 0x80-0xEF, in any state: load `run_status` and go to `WAIT_D1`. Any partial message is dropped.
- 0xF0: clear `run_status`, go to `SYSEX`.
- 0xF7: clear `run_status`, go to `IDLE`.
- 0xF1-0xF6 (system common): clear `run_status`, go to `IDLE`. Their data bytes are discarded.
- Data byte handling. Bit 7 of `data_rx` is ignored; `data_rx[6:0]` is used.
  - `IDLE` or `SYSEX`: discard.
  - `WAIT_D1`, 2-byte type: store in `d1_hold`, go to `WAIT_D2`.
  - `WAIT_D1`, 1-byte type: emit the message with `data2`=0, stay in `WAIT_D1` (running status).
  - `WAIT_D2`: emit the message with `data1`=`d1_hold` and `data2`=byte, go to `WAIT_D1` (running status).
- Emit:
  - If the channel passes the filter: load `msg_type`, `msg_channel`, `msg_data1`, `msg_data2` and pulse `msg_valid`.
  - If it fails the filter: run the state transitions anyway and leave all outputs untouched.
- Field outputs hold their last value between pulses.

## Timing

- `msg_valid` and `rt_valid` go high on the clock edge after the `new_byte_strobe` cycle that completes the message or carries the real-time byte. Latency is 1 cycle. Pulses last exactly 1 cycle.
- Field outputs change on the same edge that raises their strobe.
- Back-to-back strobes on consecutive cycles are fully supported, with no lost bytes.
- Reset values:
  - `msg_valid`, `rt_valid`: 0.
  - All field outputs: 0.
  - `rt_byte`: 0.
  - `run_status`: 0; `state`: `IDLE`.
- Assertion of `sys_rst` at any point, including mid-message or mid-SysEx, clears everything immediately. The next data bytes are discarded until a new status byte arrives.
- Status and data bytes cannot coincide; one byte is handled per strobe.

## Configuration

- `MIDI_VEL0_NOTE_OFF_EN` defined:
  - An emitted 0x9 message with `data2`=0 is reported as `msg_type`=0x8 with the same channel, note and `data2`.
  - `run_status` stays 0x9n, so following running-status note-ons still decode as 0x9.
- `MIDI_VEL0_NOTE_OFF_EN` undefined: 0x9 messages with velocity 0 are reported unchanged as 0x9.

## Test plan

- Note-on: bytes 0x90, 0x3C, 0x64 -> one `msg_valid` pulse; type=9, ch=0, d1=0x3C, d2=0x64.
- Running status: after the note-on above, send 0x3E, 0x50 -> second pulse; type=9, ch=0, d1=0x3E, d2=0x50.
- Real-time interleave: 0x92, 0x40, 0xF8, 0x7F ->
  - `rt_valid` pulse with `rt_byte`=0xF8;
  - then a `msg_valid` pulse with type=9, ch=2, d1=0x40, d2=0x7F.
- One-byte type and SysEx:
  - 0xC5, 0x07 -> pulse with type=C, ch=5, d1=7, d2=0.
  - Then 0xF0, 0x01, 0x02, 0xF7, 0x3C, 0x40 -> no `msg_valid` pulses.
- Filter: `OMNI`=0, `LISTEN_CH`=2; send 0x91, 0x3C, 0x64 then 0x92, 0x3C, 0x64 -> exactly one pulse, with ch=2.
- Vel-0 conversion and reset:
  - 0x90, 0x3C, 0x00 -> type=8 with the macro defined, type=9 without.
  - Assert `sys_rst` after 0x90, 0x3C, then send 0x64 -> no pulse; all outputs 0.

Source files
------------

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel-voice messages from a received byte stream: running status, real-time
// interleave and SysEx skipping. Define MIDI_VEL0_NOTE_OFF_EN to report vel-0 note-on as note-off.
module midi_msg_parser #(
  parameter int unsigned OMNI      = 1,
  parameter logic [3:0]  LISTEN_CH = 4'd0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] data_rx,
  input  logic       is_command,
  input  logic       new_byte_strobe,
  output logic       msg_valid,
  output logic [3:0] msg_type,
  output logic [3:0] msg_channel,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte
);

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

  state_e     state_q;
  logic [7:0] run_status_q;
  logic [6:0] d1_hold_q;

  logic       is_rt;
  logic       two_byte;
  logic       emit;
  logic       ch_ok;
  logic [6:0] emit_d1;
  logic [6:0] emit_d2;
  logic [3:0] emit_type;

  always_comb begin
    is_rt    = is_command && (data_rx[7:3] == 5'b11111);
    two_byte = !(run_status_q[7:4] inside {4'hC, 4'hD});
    emit     = 1'b0;
    emit_d1  = d1_hold_q;
    emit_d2  = data_rx[6:0];
    if (new_byte_strobe && !is_command) begin
      if (state_q == StWaitD1 && !two_byte) begin
        emit    = 1'b1;
        emit_d1 = data_rx[6:0];
        emit_d2 = 7'd0;
      end else if (state_q == StWaitD2) begin
        emit = 1'b1;
      end
    end
    emit_type = run_status_q[7:4];
`ifdef MIDI_VEL0_NOTE_OFF_EN
    // Only the reported type changes; running status keeps decoding as note-on.
    if (emit_type == 4'h9 && emit_d2 == 7'd0) begin
      emit_type = 4'h8;
    end
`endif
    ch_ok = (OMNI != 0) || (run_status_q[3:0] == LISTEN_CH);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      run_status_q <= 8'd0;
      d1_hold_q    <= 7'd0;
      msg_valid    <= 1'b0;
      msg_type     <= 4'd0;
      msg_channel  <= 4'd0;
      msg_data1    <= 7'd0;
      msg_data2    <= 7'd0;
      rt_valid     <= 1'b0;
      rt_byte      <= 8'd0;
    end else begin
      msg_valid <= 1'b0;
      rt_valid  <= 1'b0;
      // Filtered-out messages still advance the state below but leave the outputs alone.
      if (emit && ch_ok) begin
        msg_valid   <= 1'b1;
        msg_type    <= emit_type;
        msg_channel <= run_status_q[3:0];
        msg_data1   <= emit_d1;
        msg_data2   <= emit_d2;
      end
      if (new_byte_strobe) begin
        if (is_command) begin
          if (is_rt) begin
            rt_valid <= 1'b1;
            rt_byte  <= data_rx;
          end else if (data_rx[7:4] != 4'hF) begin
            run_status_q <= data_rx;
            state_q      <= StWaitD1;
          end else begin
            run_status_q <= 8'd0;
            state_q      <= (data_rx == 8'hF0) ? StSysex : StIdle;
          end
        end else begin
          unique case (state_q)
            StWaitD1: begin
              if (two_byte) begin
                d1_hold_q <= data_rx[6:0];
                state_q   <= StWaitD2;
              end
            end
            StWaitD2: state_q <= StWaitD1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Randomized and directed bench for midi_msg_parser against a message-assembly reference model.
module tb_midi_msg_parser;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] data_rx = 8'd0;
  logic       is_command = 1'b0;
  logic       new_byte_strobe = 1'b0;

  logic       msg_valid, rt_valid;
  logic [3:0] msg_type, msg_channel;
  logic [6:0] msg_data1, msg_data2;
  logic [7:0] rt_byte;
  logic       f_valid, f_rt_valid;
  logic [3:0] f_type, f_channel;
  logic [6:0] f_data1, f_data2;
  logic [7:0] f_rt_byte;

  midi_msg_parser u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_rx(data_rx), .is_command(is_command),
    .new_byte_strobe(new_byte_strobe), .msg_valid(msg_valid), .msg_type(msg_type),
    .msg_channel(msg_channel), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .rt_valid(rt_valid), .rt_byte(rt_byte)
  );

  midi_msg_parser #(.OMNI(0), .LISTEN_CH(4'd2)) u_flt (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_rx(data_rx), .is_command(is_command),
    .new_byte_strobe(new_byte_strobe), .msg_valid(f_valid), .msg_type(f_type),
    .msg_channel(f_channel), .msg_data1(f_data1), .msg_data2(f_data2),
    .rt_valid(f_rt_valid), .rt_byte(f_rt_byte)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: held status byte plus a list of collected data bytes.
  logic [7:0] m_stat;
  bit         m_have;
  logic [6:0] m_pend[$];
  logic       e_mv, e_rv, fe_mv;
  logic [3:0] e_type, e_ch, fe_type, fe_ch;
  logic [6:0] e_d1, e_d2, fe_d1, fe_d2;
  logic [7:0] e_rb;

  wire [31:0] dut_main = {msg_valid, msg_type, msg_channel, msg_data1, msg_data2, rt_valid, rt_byte};
  wire [31:0] exp_main = {e_mv, e_type, e_ch, e_d1, e_d2, e_rv, e_rb};
  wire [31:0] dut_flt  = {f_valid, f_type, f_channel, f_data1, f_data2, f_rt_valid, f_rt_byte};
  wire [31:0] exp_flt  = {fe_mv, fe_type, fe_ch, fe_d1, fe_d2, e_rv, e_rb};

  task automatic model_reset();
    m_stat = 8'd0; m_have = 1'b0; m_pend.delete();
    e_mv = 0; e_rv = 0; fe_mv = 0;
    e_type = 0; e_ch = 0; e_d1 = 0; e_d2 = 0; e_rb = 0;
    fe_type = 0; fe_ch = 0; fe_d1 = 0; fe_d2 = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    logic [6:0] d1, d2;
    logic [3:0] t;
    e_mv = 0; e_rv = 0; fe_mv = 0;
    if (b >= 8'hF8) begin
      e_rv = 1; e_rb = b;
    end else if (b[7]) begin
      m_pend.delete();
      m_have = (b < 8'hF0);
      m_stat = b;
    end else if (m_have) begin
      m_pend.push_back(b[6:0]);
      need = (m_stat[7:4] == 4'hC || m_stat[7:4] == 4'hD) ? 1 : 2;
      if (m_pend.size() == need) begin
        d1 = m_pend[0];
        d2 = (need == 2) ? m_pend[1] : 7'd0;
        m_pend.delete();
        t = m_stat[7:4];
`ifdef MIDI_VEL0_NOTE_OFF_EN
        if (t == 4'h9 && d2 == 7'd0) t = 4'h8;
`endif
        e_mv = 1; e_type = t; e_ch = m_stat[3:0]; e_d1 = d1; e_d2 = d2;
        if (m_stat[3:0] == 4'd2) begin
          fe_mv = 1; fe_type = t; fe_ch = m_stat[3:0]; fe_d1 = d1; fe_d2 = d2;
        end
      end
    end
  endtask

  // Drives one byte for one cycle, leaving time at posedge+1 for sampling.
  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    data_rx = b; is_command = b[7]; new_byte_strobe = 1'b1;
    model_byte(b);
    @(posedge sys_clk);
    #1;
    new_byte_strobe = 1'b0;
    data_rx = 8'($urandom);
    is_command = 1'($urandom);
  endtask

  task automatic idle_cycle();
    e_mv = 0; e_rv = 0; fe_mv = 0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge sys_clk);
    #1;
    n_vec++;
    if (dut_main !== 32'd0 || dut_flt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h/%h want 0/0", dut_main, dut_flt);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_note_on();
    logic [7:0] seq[$] = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50};
    foreach (seq[i]) begin
      send(seq[i]);
      n_vec++;
      if (dut_main !== exp_main) begin
        n_err++;
        $display("FAIL note_on[%0d]: got %h want %h", i, dut_main, exp_main);
      end
      if (i == 2) begin
        n_vec++;
        if ({msg_valid, msg_type, msg_channel, msg_data1, msg_data2} !== {1'b1, 4'h9, 4'h0, 7'h3C, 7'h64}) begin
          n_err++;
          $display("FAIL note_on_fields: got %b %h %h %h %h want 1 9 0 3c 64",
                   msg_valid, msg_type, msg_channel, msg_data1, msg_data2);
        end
      end
    end
    n_vec++;
    if ({msg_valid, msg_type, msg_data1, msg_data2} !== {1'b1, 4'h9, 7'h3E, 7'h50}) begin
      n_err++;
      $display("FAIL running_status: got %b %h %h %h want 1 9 3e 50",
               msg_valid, msg_type, msg_data1, msg_data2);
    end
  endtask

  task automatic test_rt_interleave();
    logic [7:0] seq[$] = '{8'h92, 8'h40, 8'hF8, 8'h7F};
    foreach (seq[i]) begin
      send(seq[i]);
      n_vec++;
      if (dut_main !== exp_main || dut_flt !== exp_flt) begin
        n_err++;
        $display("FAIL rt_interleave[%0d]: got %h/%h want %h/%h", i, dut_main, dut_flt,
                 exp_main, exp_flt);
      end
      if (i == 2) begin
        n_vec++;
        if ({rt_valid, rt_byte, msg_valid} !== {1'b1, 8'hF8, 1'b0}) begin
          n_err++;
          $display("FAIL rt_pulse: got %b %h %b want 1 f8 0", rt_valid, rt_byte, msg_valid);
        end
      end
    end
  endtask

  task automatic test_one_byte_sysex();
    logic [7:0] seq[$] = '{8'hC5, 8'h07, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'h40};
    int pulses = 0;
    foreach (seq[i]) begin
      send(seq[i]);
      if (i >= 2 && msg_valid) pulses++;
      n_vec++;
      if (dut_main !== exp_main) begin
        n_err++;
        $display("FAIL one_byte_sysex[%0d]: got %h want %h", i, dut_main, exp_main);
      end
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL sysex_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_filter();
    logic [7:0] seq[$] = '{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64};
    int pulses = 0;
    foreach (seq[i]) begin
      send(seq[i]);
      if (f_valid) pulses++;
      n_vec++;
      if (dut_flt !== exp_flt) begin
        n_err++;
        $display("FAIL filter[%0d]: got %h want %h", i, dut_flt, exp_flt);
      end
    end
    n_vec++;
    if (pulses !== 1 || f_channel !== 4'd2) begin
      n_err++;
      $display("FAIL filter_count: got %0d pulses ch %0d want 1 ch 2", pulses, f_channel);
    end
  endtask

  task automatic test_vel0();
    logic [3:0] want;
`ifdef MIDI_VEL0_NOTE_OFF_EN
    want = 4'h8;
`else
    want = 4'h9;
`endif
    send(8'h90); send(8'h3C); send(8'h00);
    n_vec++;
    if (dut_main !== exp_main || msg_type !== want || msg_valid !== 1'b1) begin
      n_err++;
      $display("FAIL vel0: got %h type %h want %h type %h", dut_main, msg_type, exp_main, want);
    end
    send(8'h3D); send(8'h22);
    n_vec++;
    if (msg_type !== 4'h9 || dut_main !== exp_main) begin
      n_err++;
      $display("FAIL vel0_running: got %h want %h", dut_main, exp_main);
    end
  endtask

  task automatic test_back_to_back();
    send(8'hB3); send(8'h07); send(8'h11);
    idle_cycle();
    n_vec++;
    if (msg_valid !== 1'b0 || dut_main !== exp_main) begin
      n_err++;
      $display("FAIL pulse_width: got %h want %h", dut_main, exp_main);
    end
  endtask

  task automatic test_reset_mid_msg();
    send(8'hFA); send(8'h90); send(8'h3C);
    #3;
    sys_rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (dut_main !== 32'd0 || dut_flt !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%h want 0/0", dut_main, dut_flt);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    send(8'h64);
    n_vec++;
    if (dut_main !== 32'd0 || dut_flt !== 32'd0) begin
      n_err++;
      $display("FAIL post_reset_data: got %h/%h want 0/0", dut_main, dut_flt);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) b = {1'b0, 7'($urandom)};
      else if (r < 52) b = 8'h00;
      else if (r < 75) b = 8'h80 + 8'($urandom_range(0, 111));
      else if (r < 82) b = {6'b100100, 2'($urandom)};
      else if (r < 92) b = 8'hF8 + 8'($urandom_range(0, 7));
      else b = 8'hF0 + 8'($urandom_range(0, 7));
      send(b);
      n_vec++;
      if (dut_main !== exp_main || dut_flt !== exp_flt) begin
        n_err++;
        $display("FAIL random[%0d] byte %h: got %h/%h want %h/%h", i, b, dut_main, dut_flt,
                 exp_main, exp_flt);
      end
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_rt_interleave();
    test_one_byte_sysex();
    test_filter();
    test_vel0();
    test_back_to_back();
    test_reset_mid_msg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
